// File: rtl/div_sequencer_pkg.sv
// Shared state encodings and handshake constants for the multi-cycle divider.
// Imported by the divider top and its test environment.
package div_sequencer_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_t;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Width of an iteration counter that wraps after w steps.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/div_sequencer_if.sv
// EX-stage <-> divider handshake bundle: the EX stage is the master, the divider the slave.
interface div_sequencer_if #(
  parameter int DATA_W = 32
);

  logic                  start_i;
  logic                  annul_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stall_req_ex_o;

  modport master (
    output start_i,
    output annul_i,
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    input  result_o,
    input  ready_o,
    input  stall_req_ex_o
  );

  modport slave (
    input  start_i,
    input  annul_i,
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    output result_o,
    output ready_o,
    output stall_req_ex_o
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract
// the divisor, keep the difference only when it did not go negative.
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_in,
  input  logic [DATA_W-1:0] quot_in,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_out,
  output logic [DATA_W-1:0] quot_out
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            fits;

  // The partial remainder is always below the divisor, so one extra bit is
  // enough for the subtract's sign to tell whether the divisor fitted.
  always_comb begin
    shifted  = {rem_in, quot_in[DATA_W-1]};
    diff     = shifted - {1'b0, divisor};
    fits     = ~diff[DATA_W];
    rem_out  = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
    quot_out = {quot_in[DATA_W-2:0], fits};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU sequencer for the EX stage: sign handling, iteration
// control and result hand-off around a single combinational div_step.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          rst,
  div_sequencer_if.slave bus
);

  localparam int                CNT_W     = cnt_width(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_STEP = CNT_W'(DATA_W - 1);

  div_state_t          state;
  div_state_t          next_state;
  logic [CNT_W-1:0]    counter;
  logic [DATA_W-1:0]   rem_q;
  logic [DATA_W-1:0]   quot_q;
  logic [DATA_W-1:0]   divisor_q;
  logic                neg_quot_q;
  logic                neg_rem_q;
  logic [2*DATA_W-1:0] result_q;

  logic                start_ok;
  logic                divisor_zero;
  logic                op1_neg;
  logic                op2_neg;
  logic [DATA_W-1:0]   op1_abs;
  logic [DATA_W-1:0]   op2_abs;
  logic [DATA_W-1:0]   rem_nx;
  logic [DATA_W-1:0]   quot_nx;
  logic [DATA_W-1:0]   rem_fix;
  logic [DATA_W-1:0]   quot_fix;
  logic                ready;
  logic                stall;

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_in   (rem_q),
    .quot_in  (quot_q),
    .divisor  (divisor_q),
    .rem_out  (rem_nx),
    .quot_out (quot_nx)
  );

  // Signed operands are divided as magnitudes; the signs only steer the final fix-up.
  always_comb begin
    start_ok     = bus.start_i & ~bus.annul_i;
    divisor_zero = (bus.opdata2_i == '0);
    op1_neg      = bus.signed_div_i & bus.opdata1_i[DATA_W-1];
    op2_neg      = bus.signed_div_i & bus.opdata2_i[DATA_W-1];
    op1_abs      = op1_neg ? (~bus.opdata1_i + 1'b1) : bus.opdata1_i;
    op2_abs      = op2_neg ? (~bus.opdata2_i + 1'b1) : bus.opdata2_i;
    quot_fix     = neg_quot_q ? (~quot_nx + 1'b1) : quot_nx;
    rem_fix      = neg_rem_q  ? (~rem_nx + 1'b1)  : rem_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= DivFree;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DivFree: begin
        if (start_ok) next_state = divisor_zero ? DivByZero : DivOn;
      end
      DivByZero: begin
        next_state = bus.annul_i ? DivFree : DivEnd;
      end
      DivOn: begin
        if (bus.annul_i)               next_state = DivFree;
        else if (counter == LAST_STEP) next_state = DivEnd;
      end
      DivEnd: begin
        if (bus.annul_i || bus.start_i == DivStop) next_state = DivFree;
      end
      default: next_state = DivFree;
    endcase
  end

  // Reset gates the stall request so a held start_i cannot freeze the pipe during reset.
  always_comb begin
    ready = (state == DivEnd) ? DivResultReady : DivResultNotReady;
    stall = rst & bus.start_i & ~bus.annul_i & ~ready;
  end

  // An annulled op leaves result_q untouched; only a normal hand-off clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      counter    <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      divisor_q  <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= '0;
    end else begin
      unique case (state)
        DivFree: begin
          if (start_ok && !divisor_zero) begin
            rem_q      <= '0;
            quot_q     <= op1_abs;
            divisor_q  <= op2_abs;
            neg_quot_q <= op1_neg ^ op2_neg;
            neg_rem_q  <= op1_neg;
            counter    <= '0;
          end
        end
        DivByZero: begin
          if (!bus.annul_i) result_q <= '0;
        end
        DivOn: begin
          if (!bus.annul_i) begin
            rem_q   <= rem_nx;
            quot_q  <= quot_nx;
            counter <= counter + 1'b1;
            if (counter == LAST_STEP) result_q <= {rem_fix, quot_fix};
          end
        end
        DivEnd: begin
          if (!bus.annul_i && bus.start_i == DivStop) result_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.result_o       = result_q;
  assign bus.ready_o        = ready;
  assign bus.stall_req_ex_o = stall;

endmodule
